// File: rtl/instr_sequencer.sv
// Multi-cycle phase sequencer: emits per-phase enables (IR load, memory, RF write, PC update)
// under a run/step/halt debug interface and counts retired instructions.
module instr_sequencer #(
    parameter int unsigned CNT_W   = 32,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic [5:0]       opcode,
    input  logic [1:0]       mem_op,
    input  logic [2:0]       rf_wr_in,
    output logic             ir_we,
    output logic             mem_en,
    output logic [2:0]       rf_wr,
    output logic             pc_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        StHalt   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic             step_mode_q, step_mode_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHalt;
            step_mode_q <= 1'b0;
            halt_pend_q <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            halt_pend_q <= halt_pend_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        retire      = 1'b0;
        unique case (state_q)
            StHalt: begin
                if (run) begin
                    state_d     = StFetch;
                    step_mode_d = 1'b0;
                end else if (step) begin
                    state_d     = StFetch;
                    step_mode_d = 1'b1;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (opcode == HALT_OP) begin
                    retire  = 1'b1;
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: state_d = (mem_op != 2'b00) ? StMem : StWb;
            StMem:  state_d = StWb;
            StWb: begin
                retire = 1'b1;
                // A halt_req landing in WB itself must stop at this boundary.
                if (halt_pend_q || halt_req || step_mode_q || !run) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                end
            end
            default: state_d = StHalt;
        endcase

        if (state_d == StHalt && state_q != StHalt) begin
            halt_pend_d = 1'b0;
        end else if (state_q != StHalt && halt_req) begin
            halt_pend_d = 1'b1;
        end else begin
            halt_pend_d = halt_pend_q;
        end

        instr_cnt_d = retire ? instr_cnt_q + 1'b1 : instr_cnt_q;
    end

    always_comb begin
        ir_we     = (state_q == StFetch);
        mem_en    = (state_q == StMem);
        pc_we     = (state_q == StWb) || (state_q == StDecode && opcode == HALT_OP);
        rf_wr     = (state_q == StWb) ? rf_wr_in : 3'b000;
        state     = state_q;
        halted    = (state_q == StHalt);
        instr_cnt = instr_cnt_q;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (counter narrowed to 4 bits to reach wrap).
module tb_instr_sequencer;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst, run, step, halt_req;
    logic [5:0]    opcode;
    logic [1:0]    mem_op;
    logic [2:0]    rf_wr_in;
    logic          ir_we, mem_en, pc_we, halted;
    logic [2:0]    rf_wr, state;
    logic [CW-1:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    instr_sequencer #(.CNT_W(CW), .HALT_OP(6'h3F)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .step     (step),
        .halt_req (halt_req),
        .opcode   (opcode),
        .mem_op   (mem_op),
        .rf_wr_in (rf_wr_in),
        .ir_we    (ir_we),
        .mem_en   (mem_en),
        .rf_wr    (rf_wr),
        .pc_we    (pc_we),
        .state    (state),
        .halted   (halted),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Packed view of the strobes: {ir_we, mem_en, pc_we, rf_wr}
    function automatic logic [5:0] outs();
        return {ir_we, mem_en, pc_we, rf_wr};
    endfunction

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        opcode = 6'h00; mem_op = 2'b00; rf_wr_in = 3'b101;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_outs", 32'(outs()), 32'd0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("idle_halt", 32'(state), 32'd0);

        // Free run, non-memory instructions
        run = 1'b1;
        tick(1);
        chk("run_fetch", 32'(state), 32'd1);
        chk("run_fetch_outs", 32'(outs()), 32'b100000);
        tick(1);
        chk("run_decode_outs", 32'(outs()), 32'd0);
        tick(1);
        chk("run_exec", 32'(state), 32'd3);
        tick(1);
        chk("run_wb", 32'(state), 32'd5);
        chk("run_wb_outs", 32'(outs()), 32'b001101);
        tick(1);
        chk("period1", 32'(state), 32'd1);
        chk("cnt1", 32'(instr_cnt), 32'd1);
        tick(4);
        chk("period2", 32'(state), 32'd1);
        tick(4);
        chk("period3", 32'(state), 32'd1);
        chk("cnt3", 32'(instr_cnt), 32'd3);

        // Memory instruction; run dropped during WB stops at this boundary
        mem_op = 2'b01; rf_wr_in = 3'b011;
        tick(2);
        chk("mem_exec", 32'(state), 32'd3);
        tick(1);
        chk("mem_state", 32'(state), 32'd4);
        chk("mem_outs", 32'(outs()), 32'b010000);
        tick(1);
        chk("mem_wb", 32'(state), 32'd5);
        chk("mem_wb_outs", 32'(outs()), 32'b001011);
        run = 1'b0;
        tick(1);
        chk("run_drop_halt", 32'(state), 32'd0);
        chk("cnt4", 32'(instr_cnt), 32'd4);
        tick(2);
        chk("stay_halt", 32'(halted), 32'd1);

        // Single step; a second step during EXEC is ignored
        mem_op = 2'b00;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        chk("step_fetch", 32'(state), 32'd1);
        tick(2);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        chk("step_wb", 32'(state), 32'd5);
        tick(1);
        chk("step_halt", 32'(halted), 32'd1);
        chk("cnt5", 32'(instr_cnt), 32'd5);
        tick(2);
        chk("step_no_rerun", 32'(state), 32'd0);

        // halt_req during DECODE
        run = 1'b1;
        tick(2);
        chk("hr_decode", 32'(state), 32'd2);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        tick(1);
        chk("hr_wb_pcwe", 32'(pc_we), 32'd1);
        tick(1);
        chk("hr_halt", 32'(state), 32'd0);
        chk("cnt6", 32'(instr_cnt), 32'd6);

        // halt_req exactly in WB
        tick(4);
        chk("hr2_wb", 32'(state), 32'd5);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        chk("hr2_halt", 32'(state), 32'd0);
        chk("cnt7", 32'(instr_cnt), 32'd7);

        // halt_req while halted is ignored: next instruction runs straight through WB
        run = 1'b0;
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        run = 1'b1;
        tick(5);
        chk("hr_ignored", 32'(state), 32'd1);
        chk("cnt8", 32'(instr_cnt), 32'd8);

        // HALT_OP retires from DECODE
        opcode = 6'h3F;
        tick(1);
        chk("hop_decode", 32'(state), 32'd2);
        chk("hop_outs", 32'(outs()), 32'b001000);
        tick(1);
        chk("hop_halt", 32'(state), 32'd0);
        chk("cnt9", 32'(instr_cnt), 32'd9);

        // Async reset in MEM
        opcode = 6'h00; mem_op = 2'b01;
        tick(4);
        chk("ar_mem", 32'(state), 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_outs", 32'(outs()), 32'd0);
        chk("ar_cnt", 32'(instr_cnt), 32'd0);
        tick(1);
        chk("ar_hold", 32'(state), 32'd0);
        rst = 1'b0;

        // Counter wrap over 16 retirements
        mem_op = 2'b00;
        tick(1);
        chk("wrap_fetch", 32'(state), 32'd1);
        tick(60);
        chk("cnt15", 32'(instr_cnt), 32'd15);
        tick(4);
        chk("wrap_cnt", 32'(instr_cnt), 32'd0);
        chk("wrap_state", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
